// File: rtl/pll_reset_seq_pkg.sv
// Shared types, default parameters and sizing helper for the PLL supervisor
// and reset sequencer.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    ASSERT_ARESET,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_ARESET_CYCLES = 10;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_NUM_DOMAINS   = 4;
  localparam int unsigned DEF_STAGE_GAP     = 16;
  localparam int unsigned RELOCK_W          = 8;

  // The shared counter must hold the longest interval any state measures.
  function automatic int unsigned cnt_width(input int unsigned lock_timeout,
                                            input int unsigned stable_cycles,
                                            input int unsigned release_span,
                                            input int unsigned areset_cycles);
    int unsigned m;
    m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (release_span > m)  m = release_span;
    if (areset_cycles > m) m = areset_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// PLL-facing and domain-reset signals of the reset sequencer.
interface pll_reset_seq_if #(
  parameter int unsigned NUM_DOMAINS = 4
);
  logic                   pll_locked;
  logic                   pll_areset;
  logic [NUM_DOMAINS-1:0] rst_out_n;
  logic                   ready;
  logic [7:0]             relock_count;
  logic                   timeout_err;

  modport master (
    input  pll_locked,
    output pll_areset,
    output rst_out_n,
    output ready,
    output relock_count,
    output timeout_err
  );

  modport slave (
    output pll_locked,
    input  pll_areset,
    input  rst_out_n,
    input  ready,
    input  relock_count,
    input  timeout_err
  );
endinterface

// File: rtl/pll_reset_seq_sync_bit.sv
// N-stage single-bit synchroniser, asynchronously cleared to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_seq.sv
// PLL supervisor: pulses pll_areset, filters lock, releases per-domain resets
// in a staggered order and re-sequences on lock loss or lock timeout.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned ARESET_CYCLES = DEF_ARESET_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned NUM_DOMAINS   = DEF_NUM_DOMAINS,
  parameter int unsigned STAGE_GAP     = DEF_STAGE_GAP
) (
  input logic             clk_50m,
  input logic             reset_n,
  pll_reset_seq_if.master bus
);
  localparam int unsigned CNT_W = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES,
                                            NUM_DOMAINS * STAGE_GAP, ARESET_CYCLES);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t ARESET_LAST  = cnt_t'(ARESET_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t RELEASE_LAST = cnt_t'((NUM_DOMAINS - 1) * STAGE_GAP);

  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d, cnt_inc;
  logic                  pll_areset_q, pll_areset_d;
  logic [NUM_DOMAINS-1:0] rst_out_n_q, rst_out_n_d;
  logic                  ready_q, ready_d;
  logic [RELOCK_W-1:0]   relock_count_q, relock_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  locked_s;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk_50m),
    .rst_n(reset_n),
    .d    (bus.pll_locked),
    .q    (locked_s)
  );

  always_comb begin
    state_d        = state_q;
    cnt_inc        = cnt_q + 1'b1;
    cnt_d          = cnt_inc;
    pll_areset_d   = pll_areset_q;
    rst_out_n_d    = rst_out_n_q;
    ready_d        = ready_q;
    relock_count_d = relock_count_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      ASSERT_ARESET: begin
        if (cnt_q == ARESET_LAST) begin
          state_d      = WAIT_LOCK;
          cnt_d        = '0;
          pll_areset_d = 1'b0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = ASSERT_ARESET;
          cnt_d         = '0;
          pll_areset_d  = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          // Domain 0 is released on the edge that enters RELEASE.
          cnt_d          = '0;
          rst_out_n_d[0] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE, RUN: begin
        if (!locked_s) begin
          state_d      = ASSERT_ARESET;
          cnt_d        = '0;
          pll_areset_d = 1'b1;
          rst_out_n_d  = '0;
          ready_d      = 1'b0;
          if (relock_count_q != '1) relock_count_d = relock_count_q + 1'b1;
        end else if (state_q == RUN) begin
          cnt_d = cnt_q;
        end else begin
          // cnt_inc counts cycles since domain 0 went high.
          for (int unsigned i = 1; i < NUM_DOMAINS; i++) begin
            if (cnt_inc == cnt_t'(i * STAGE_GAP)) rst_out_n_d[i] = 1'b1;
          end
          if (cnt_inc == RELEASE_LAST) begin
            ready_d = 1'b1;
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d      = ASSERT_ARESET;
        cnt_d        = '0;
        pll_areset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ASSERT_ARESET;
      cnt_q          <= '0;
      pll_areset_q   <= 1'b1;
      rst_out_n_q    <= '0;
      ready_q        <= 1'b0;
      relock_count_q <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_areset_q   <= pll_areset_d;
      rst_out_n_q    <= rst_out_n_d;
      ready_q        <= ready_d;
      relock_count_q <= relock_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.pll_areset   = pll_areset_q;
  assign bus.rst_out_n    = rst_out_n_q;
  assign bus.ready        = ready_q;
  assign bus.relock_count = relock_count_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed bring-up/fault scenarios plus random lock
// toggling, checked against a timestamp-based reference model.
module tb_pll_reset_seq;
  localparam int SYNC    = 2;
  localparam int ARESET  = 4;
  localparam int TIMEOUT = 100;
  localparam int STABLE  = 8;
  localparam int NUM     = 4;
  localparam int GAP     = 4;
  localparam int LAT     = SYNC + STABLE + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pll_reset_seq_if #(.NUM_DOMAINS(NUM)) bus_if ();

  pll_reset_seq #(
    .SYNC_STAGES  (SYNC),
    .ARESET_CYCLES(ARESET),
    .LOCK_TIMEOUT (TIMEOUT),
    .STABLE_CYCLES(STABLE),
    .NUM_DOMAINS  (NUM),
    .STAGE_GAP    (GAP)
  ) dut (
    .clk_50m(clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase plus the edge number at which it began; outputs
  // follow from elapsed edges. Phases: areset, wait, stable, released.
  localparam int P_AR = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3;
  int              m_phase = P_AR;
  int              m_t0 = 0;
  int              m_n = 0;
  int              m_relock = 0;
  bit              m_terr = 1'b0;
  logic [SYNC-1:0] m_sync = '0;

  always @(posedge clk or negedge reset_n) begin : model
    int ph, t0, rc, el;
    bit te, ls;
    if (!reset_n) begin
      m_phase  <= P_AR;
      m_t0     <= 0;
      m_n      <= 0;
      m_relock <= 0;
      m_terr   <= 1'b0;
      m_sync   <= '0;
    end else begin
      ls = m_sync[SYNC-1];
      ph = m_phase; t0 = m_t0; rc = m_relock; te = m_terr;
      el = (m_n + 1) - m_t0;
      case (m_phase)
        P_AR:   if (el == ARESET) begin ph = P_WAIT; t0 = m_n + 1; end
        P_WAIT: if (ls) begin ph = P_STAB; t0 = m_n + 1; end
                else if (el == TIMEOUT) begin te = 1'b1; ph = P_AR; t0 = m_n + 1; end
        P_STAB: if (!ls) begin ph = P_WAIT; t0 = m_n + 1; end
                else if (el == STABLE) begin ph = P_REL; t0 = m_n + 1; end
        default: if (!ls) begin
                   ph = P_AR; t0 = m_n + 1;
                   if (rc < 255) rc = rc + 1;
                 end
      endcase
      m_phase  <= ph;
      m_t0     <= t0;
      m_relock <= rc;
      m_terr   <= te;
      m_n      <= m_n + 1;
      m_sync   <= {m_sync[SYNC-2:0], bus_if.pll_locked};
    end
  end

  always @(negedge clk) begin : scoreboard
    logic [NUM-1:0] e_rst;
    int el;
    el = m_n - m_t0;
    for (int i = 0; i < NUM; i++) e_rst[i] = (m_phase == P_REL) && (el >= i * GAP);
    check("sb_pll_areset", bus_if.pll_areset, m_phase == P_AR);
    check("sb_rst_out_n", bus_if.rst_out_n, e_rst);
    check("sb_ready", bus_if.ready, (m_phase == P_REL) && (el >= (NUM - 1) * GAP));
    check("sb_relock_count", bus_if.relock_count, m_relock);
    check("sb_timeout_err", bus_if.timeout_err, m_terr);
  end

  int first_hi [NUM];
  int ready_hi;
  int ar_hi;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset_n = 1'b0;
    @(negedge clk); #2 reset_n = 1'b1;
  endtask

  // Raise lock now; record the cycle each output first goes high.
  task automatic measure_release(input int glitch_at);
    for (int i = 0; i < NUM; i++) first_hi[i] = -1;
    ready_hi = -1;
    ar_hi = 0;
    bus_if.pll_locked = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) if (first_hi[i] < 0 && bus_if.rst_out_n[i]) first_hi[i] = k;
      if (ready_hi < 0 && bus_if.ready) ready_hi = k;
      if (bus_if.pll_areset) ar_hi++;
      if (k == glitch_at) bus_if.pll_locked = 1'b0;
      if (glitch_at > 0 && k == glitch_at + 1) bus_if.pll_locked = 1'b1;
    end
  endtask

  task automatic check_release(input string tag, input int base);
    for (int i = 0; i < NUM; i++) check($sformatf("%s_bit%0d", tag, i), first_hi[i], base + i * GAP);
    check({tag, "_ready"}, ready_hi, base + (NUM - 1) * GAP);
    check({tag, "_areset_hi"}, ar_hi, 0);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit seen3;
    bus_if.pll_locked = 1'b0;

    // Reset values
    tick(3);
    check("rst_areset", bus_if.pll_areset, 1);
    check("rst_rst_out_n", bus_if.rst_out_n, 0);
    check("rst_ready", bus_if.ready, 0);
    check("rst_relock", bus_if.relock_count, 0);
    check("rst_timeout", bus_if.timeout_err, 0);

    // 1: normal bring-up
    #2 reset_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (bus_if.pll_areset && k < 50);
    check("t1_areset_len", k, ARESET);
    tick(20 - ARESET);
    measure_release(0);
    check_release("t1", LAT);
    check("t1_relock", bus_if.relock_count, 0);

    // 2: one-cycle lock glitch while in STABLE
    bus_if.pll_locked = 1'b0;
    do_reset();
    tick(20);
    measure_release(5);
    check_release("t2", 5 + 1 + LAT);
    check("t2_relock", bus_if.relock_count, 0);

    // 3: lock timeout
    bus_if.pll_locked = 1'b0;
    do_reset();
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_if.timeout_err && k < 300);
    check("t3_timeout_cycle", k, ARESET + TIMEOUT);
    check("t3_areset_again", bus_if.pll_areset, 1);
    k = 0;
    do begin @(negedge clk); k++; end while (bus_if.pll_areset && k < 50);
    check("t3_areset_len", k, ARESET);
    measure_release(0);
    check_release("t3", LAT);
    check("t3_timeout_sticky", bus_if.timeout_err, 1);

    // 4: lock loss in RUN
    bus_if.pll_locked = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 2) check("t4_ready_still", bus_if.ready, 1);
      if (j == 3) begin
        check("t4_rst_out_n", bus_if.rst_out_n, 0);
        check("t4_ready", bus_if.ready, 0);
        check("t4_areset", bus_if.pll_areset, 1);
        check("t4_relock", bus_if.relock_count, 1);
      end
    end
    measure_release(0);
    check_release("t4", LAT);

    // 5: lock loss during RELEASE
    bus_if.pll_locked = 1'b0;
    @(negedge clk);
    bus_if.pll_locked = 1'b1;
    k = 0;
    while (bus_if.rst_out_n != 4'b0011 && k < 100) begin @(negedge clk); k++; end
    check("t5_reach_0011", bus_if.rst_out_n, 4'b0011);
    check("t5_relock_before", bus_if.relock_count, 2);
    bus_if.pll_locked = 1'b0;
    seen3 = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (bus_if.rst_out_n[3]) seen3 = 1'b1;
      if (j == 3) begin
        check("t5_rst_out_n", bus_if.rst_out_n, 0);
        check("t5_relock", bus_if.relock_count, 3);
      end
    end
    check("t5_bit3_never", seen3, 0);

    // Random lock toggling against the model
    for (int s = 0; s < 50; s++) begin
      bus_if.pll_locked = 1'b1;
      tick($urandom_range(40, 1));
      bus_if.pll_locked = 1'b0;
      tick($urandom_range(5, 1));
    end

    // 6a: saturation of relock_count
    for (int n = 0; n < 300; n++) begin
      bus_if.pll_locked = 1'b1;
      k = 0;
      while (!bus_if.rst_out_n[0] && k < 200) begin @(negedge clk); k++; end
      if (!bus_if.rst_out_n[0]) begin
        check("t6_release_reached", bus_if.rst_out_n[0], 1);
        break;
      end
      bus_if.pll_locked = 1'b0;
      @(negedge clk);
      bus_if.pll_locked = 1'b1;
      tick(2);
    end
    check("t6_relock_sat", bus_if.relock_count, 255);

    // 6b: asynchronous reset mid-RELEASE
    k = 0;
    while (bus_if.rst_out_n != 4'b0011 && k < 200) begin @(negedge clk); k++; end
    check("t6_reach_0011", bus_if.rst_out_n, 4'b0011);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_areset", bus_if.pll_areset, 1);
    check("t6_async_rst_out_n", bus_if.rst_out_n, 0);
    check("t6_async_ready", bus_if.ready, 0);
    check("t6_async_relock", bus_if.relock_count, 0);
    check("t6_async_timeout", bus_if.timeout_err, 0);
    @(negedge clk); #2 reset_n = 1'b1;
    k = 0;
    while (!bus_if.ready && k < 200) begin @(negedge clk); k++; end
    check("t6_restart_ready", bus_if.ready, 1);
    check("t6_restart_cycles", k, ARESET + 1 + STABLE + (NUM - 1) * GAP);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
